// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide.
// The pipeline stalls on busy and picks up result on the single-cycle done pulse.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [31:0] result_q, result_d;

  logic        a_signed, b_signed, is_div, a_neg, b_neg, div_ovf;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_diff;
  logic [63:0] mul_next, div_next, prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_sel;

  assign a_signed = (funct3_q == 3'b001) || (funct3_q == 3'b010) ||
                    (funct3_q == 3'b100) || (funct3_q == 3'b110);
  assign b_signed = (funct3_q == 3'b001) || (funct3_q == 3'b100) || (funct3_q == 3'b110);
  assign is_div   = funct3_q[2];
  assign a_neg    = a_signed & a_q[31];
  assign b_neg    = b_signed & b_q[31];
  assign a_mag    = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag    = b_neg ? (~b_q + 32'd1) : b_q;
  // Signed-overflow case (most negative / -1); only meaningful for DIV and REM.
  assign div_ovf  = !funct3_q[0] && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

  // Multiply step: conditional add into the upper half, then shift right with the carry.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Divide step: {remainder, quotient} shifted left, trial subtract on the 33-bit remainder.
  assign div_diff = acc_q[63:31] - {1'b0, opnd_q};
  assign div_next = div_diff[32] ? {acc_q[62:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};

  assign prod_fix = neg_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix  = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    fix_sel = prod_fix[63:32];
    case (funct3_q)
      3'b000:         fix_sel = prod_fix[31:0];
      3'b100, 3'b101: fix_sel = quo_fix;
      3'b110, 3'b111: fix_sel = rem_fix;
      default:        fix_sel = prod_fix[63:32];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          funct3_d = funct3;
          a_d      = op_a;
          b_d      = op_b;
          state_d  = S_PREP;
        end
      end
      S_PREP: begin
        cnt_d   = 6'd0;
        neg_d   = (is_div && funct3_q[1]) ? a_neg : (a_neg ^ b_neg);
        state_d = S_ITER;
        if (is_div) begin
          opnd_d = b_mag;
          acc_d  = {32'd0, a_mag};
          if (b_q == 32'd0) begin
            result_d = funct3_q[1] ? a_q : 32'hFFFF_FFFF;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = funct3_q[1] ? 32'd0 : 32'h8000_0000;
            state_d  = S_DONE;
          end
        end else begin
          opnd_d = a_mag;
          acc_d  = {32'd0, b_mag};
        end
      end
      S_ITER: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_sel;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      funct3_q <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 6'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed RV32M vectors, random ops, flush, reset and start-while-busy.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] prev_res;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbx, p;
    logic [63:0] ua, ub;
    sa  = {{32{a[31]}}, a};
    sbx = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    p   = 64'd0;
    case (f)
      3'd0: p = ua * ub;
      3'd1: p = sa * sbx;
      3'd2: p = sa * $signed(ub);
      3'd3: p = ua * ub;
      default: ;
    endcase
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sbx;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sbx;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 2;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  // Called on a negedge in an IDLE cycle; returns on the negedge of the IDLE cycle after done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input bit hold);
    int  cyc;
    int  lat;
    bit  got;
    logic [31:0] e;
    e = model(f, a, b);
    chk("model_vs_table", e, want);
    sb.push_back(want);
    lat = exp_latency(f, a, b);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    got = 1'b0;
    for (cyc = 1; cyc < 60; cyc++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      chk("busy_during_op", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    if (got) begin
      chk("done_latency", cyc, lat);
      chk("busy_in_done", {31'd0, busy}, 32'd1);
      chk("result", result, sb.pop_front());
      $display("op f=%0d a=%h b=%h result=%h done_cycle=%0d", f, a, b, result, cyc);
      start = 1'b0;
    end else begin
      chk("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    prev_res = want;
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_after_done", {31'd0, done}, 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
    prev_res = 32'd0;
    wait_cycles(3);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Flush in ITER with counter at 10 (cycle 12 after start).
    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cycles(11);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_result_kept", result, prev_res);
    $display("flush in ITER: busy=%0d done=%0d result=%h", busy, done, result);
    run_op(3'd3, 32'd1234, 32'd5678, 32'd0, 1'b0);

    // Flush coincident with start in IDLE drops the start.
    funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_dropped", {31'd0, busy}, 32'd0);
    $display("start with flush in IDLE: busy=%0d", busy);

    // Reset while iterating.
    funct3 = 3'd1; op_a = 32'd77; op_b = 32'd88; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cycles(14);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    $display("reset in ITER: busy=%0d done=%0d result=%h", busy, done, result);

    // Start held high through the whole op, including DONE: no second launch.
    run_op(3'd0, 32'd12, 32'd12, 32'd144, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("no_relaunch_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    $display("held start: no relaunch, result=%h", result);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = $urandom();
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      run_op(f, a, b, model(f, a, b), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle sequencer for the RV32M multiply/divide instructions. Sits beside the single-cycle ALU in the execute stage. Control decode steers OP-opcode instructions with funct7=0000001 here instead of to the ALU. It runs a 32-step radix-2 shift-add multiply or restoring divide, and stalls the pipeline through a start/busy/done handshake.

Parameters:
XLEN, 32, operand and result width; only 32 is supported.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  reset; synchronous and active-low
start  in  1  request; sampled only while the block is idle (busy=0)
funct3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  in  32  rs1 value; multiplicand or dividend
op_b  in  32  rs2 value; multiplier or divisor
flush  in  1  abort the in-flight operation (branch mispredict or trap)
busy  out  1  high from the cycle after start is accepted until the cycle done is high, inclusive; drives pipeline stall
done  out  1  single-cycle pulse; result valid in that cycle
result  out  32  operation result; holds its value until the next accepted start

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, busy=0, done=0, result=0, all internal registers cleared. Reset overrides start and flush and aborts any operation in progress.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - If start=1, latch funct3, op_a and op_b, then go to PREP. busy=1 from the next cycle.
  - If start=0, stay in IDLE.
- PREP:
  - Compute operand magnitudes. op_a is signed for MULH, MULHSU, DIV and REM. op_b is signed for MULH, DIV and REM.
  - Record the result sign: a_sign XOR b_sign for MUL-type ops and quotients; a_sign for remainders.
  - Load the 64-bit accumulator and the 6-bit counter=0.
  - Special cases skip ITER and FIX and go straight to DONE:
    - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
    - DIV with op_a=0x80000000 and op_b=0xFFFFFFFF: quotient 0x80000000. REM in the same case gives 0.
  - Otherwise go to ITER.
- ITER (exactly 32 cycles, counter 0..31; leave to FIX when counter=31):
  - Multiply: if the accumulator LSB is 1, add the multiplicand into the upper 33 bits, then shift right 1.
  - Divide: shift the {remainder, quotient} pair left 1 and trial-subtract the divisor from the remainder. If the 33-bit difference is non-negative, keep it and set the quotient LSB=1; otherwise restore.
- FIX (1 cycle):
  - Negate the product or quotient/remainder (two's complement) if the recorded sign is 1.
  - Select the output: low 32 bits for MUL; high 32 bits for MULH, MULHSU and MULHU; quotient for DIV/DIVU; remainder for REM/REMU.
  - Register the selection into result.
- DONE (1 cycle): done=1 and busy=1, then go to IDLE.
  - A start in the DONE cycle is ignored.
  - A start in the following IDLE cycle is accepted.
- Latency, counting the start cycle as cycle 0:
  - Normal path: done in cycle 35.
  - Special-case path: done in cycle 2.
- Multiply product width is 64 bits. MULHSU treats op_b as unsigned; its product sign is the sign of op_a only.
- flush=1 in any non-IDLE state: next state IDLE, busy=0 and done=0 next cycle, result unchanged. Flush in IDLE has no effect. Flush coincident with start in IDLE drops the start.
- start while busy=1 is ignored, with no queueing.
- The operand, funct3 and result registers hold their values when not updated.

Test Plan:
- Reset then MUL: op_a=7, op_b=0xFFFFFFFD (-3) -> done in cycle 35, result=0xFFFFFFEB (-21); busy high cycles 1..35; done high only in cycle 35.
- MULH 0x80000000 x 0x80000000 -> result 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFF.
- DIV -7/2 -> result 0xFFFFFFFD (-3). REM -7/2 -> result 0xFFFFFFFF (-1). DIVU 100/7 -> result 14. REMU 100/7 -> result 2.
- Special cases: DIVU x/0 with op_a=5 -> result 0xFFFFFFFF, done in cycle 2. REM 5/0 -> result 5. DIV 0x80000000/0xFFFFFFFF -> result 0x80000000. REM of the same operands -> result 0.
- flush asserted in ITER cycle 10 -> busy=0 and done never pulses; result keeps its previous value; a new start one cycle later completes normally.
- rst_n=0 during ITER -> busy=0, done=0 and result=0 from the next cycle. A start held during busy, including during DONE, does not launch a second operation.
